// File: rtl/irq_controller.sv
// Machine-level interrupt controller: fixed-priority selection of enabled level requests,
// trap/exception/mret sequencing and one-hot completion acknowledge to the serviced source.
module irq_controller #(
    parameter int unsigned IRQ_NUM    = 16,
    parameter int unsigned CAUSE_BASE = 16
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [IRQ_NUM-1:0] irq_req_i,
    input  logic [IRQ_NUM-1:0] mie_i,
    input  logic               exception_i,
    input  logic               mret_i,
    output logic               irq_o,
    output logic [31:0]        irq_cause_o,
    output logic [IRQ_NUM-1:0] irq_ret_o
);

    localparam int unsigned IDX_W = (IRQ_NUM > 1) ? $clog2(IRQ_NUM) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_IRQ,
        ST_EXC,
        ST_IRQ_EXC
    } state_t;

    state_t             state;
    logic [IDX_W-1:0]   svc_idx;
    logic [IRQ_NUM-1:0] pending;
    logic [IDX_W-1:0]   sel_idx;
    logic               take;
    logic               ack;

    assign pending = irq_req_i & mie_i;

    // Lowest set index wins: scan downwards so the last hit is the smallest index.
    always_comb begin
        sel_idx = '0;
        for (int i = int'(IRQ_NUM) - 1; i >= 0; i--) begin
            if (pending[i]) begin
                sel_idx = IDX_W'(i);
            end
        end
    end

    // Trap request and completion are gated by reset so nothing leaks out while it is held.
    assign take = (state == ST_IDLE) && (|pending) && !exception_i && !rst_i;
    assign ack  = (state == ST_IRQ) && mret_i && !exception_i && !rst_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state   <= ST_IDLE;
            svc_idx <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (exception_i) begin
                        state <= ST_EXC;
                    end else if (|pending) begin
                        state   <= ST_IRQ;
                        svc_idx <= sel_idx;
                    end
                end
                ST_IRQ: begin
                    if (exception_i) begin
                        state <= ST_IRQ_EXC;
                    end else if (mret_i) begin
                        state <= ST_IDLE;
                    end
                end
                ST_EXC: begin
                    if (mret_i) begin
                        state <= ST_IDLE;
                    end
                end
                ST_IRQ_EXC: begin
                    if (mret_i) begin
                        state <= ST_IRQ;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign irq_o       = take;
    assign irq_cause_o = 32'h8000_0000 | (32'(CAUSE_BASE) + 32'(take ? sel_idx : svc_idx));

    always_comb begin
        irq_ret_o = '0;
        for (int i = 0; i < int'(IRQ_NUM); i++) begin
            irq_ret_o[i] = ack && (svc_idx == IDX_W'(i));
        end
    end

endmodule

// File: tb/tb_irq_controller.sv
// Directed bench for irq_controller: inputs change on the falling edge, outputs are checked
// 1 time unit later, so every step covers exactly one rising edge.
module tb_irq_controller;

    logic        clk_i;
    logic        rst_i;
    logic [15:0] irq_req_i;
    logic [15:0] mie_i;
    logic        exception_i;
    logic        mret_i;
    logic        irq_o;
    logic [31:0] irq_cause_o;
    logic [15:0] irq_ret_o;

    int errors = 0;
    int checks = 0;

    irq_controller #(.IRQ_NUM(16), .CAUSE_BASE(16)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .irq_req_i   (irq_req_i),
        .mie_i       (mie_i),
        .exception_i (exception_i),
        .mret_i      (mret_i),
        .irq_o       (irq_o),
        .irq_cause_o (irq_cause_o),
        .irq_ret_o   (irq_ret_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic drive(input logic [15:0] req, input logic [15:0] mie,
                         input logic exc, input logic mret, input logic rst);
        @(negedge clk_i);
        irq_req_i   = req;
        mie_i       = mie;
        exception_i = exc;
        mret_i      = mret;
        rst_i       = rst;
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic expect_out(input string tag, input logic irq,
                              input logic [31:0] cause, input logic [15:0] ret);
        chk({tag, ".irq"},   32'(irq_o),     32'(irq));
        chk({tag, ".cause"}, irq_cause_o,    cause);
        chk({tag, ".ret"},   32'(irq_ret_o), 32'(ret));
    endtask

    initial begin
        rst_i       = 1'b1;
        irq_req_i   = 16'h0001;
        mie_i       = 16'hFFFF;
        exception_i = 1'b0;
        mret_i      = 1'b0;
        #1;
        expect_out("reset_hold", 1'b0, 32'h8000_0010, 16'h0000);

        // Source 0 taken, then serviced and acknowledged
        drive(16'h0001, 16'hFFFF, 0, 0, 0);
        expect_out("take_src0", 1'b1, 32'h8000_0010, 16'h0000);
        drive(16'h0002, 16'hFFFF, 0, 0, 0);
        expect_out("irq_ignores_req", 1'b0, 32'h8000_0010, 16'h0000);
        drive(16'h0000, 16'hFFFF, 0, 1, 0);
        expect_out("mret_src0", 1'b0, 32'h8000_0010, 16'h0001);
        drive(16'h0000, 16'hFFFF, 0, 0, 0);
        expect_out("idle_quiet", 1'b0, 32'h8000_0010, 16'h0000);
        drive(16'h0001, 16'h0000, 0, 0, 0);
        expect_out("masked_req", 1'b0, 32'h8000_0010, 16'h0000);

        // Masking and priority
        drive(16'h0014, 16'h0010, 0, 0, 0);
        expect_out("take_src4", 1'b1, 32'h8000_0014, 16'h0000);
        drive(16'h0000, 16'hFFFF, 0, 1, 0);
        expect_out("mret_src4", 1'b0, 32'h8000_0014, 16'h0010);
        drive(16'h0014, 16'hFFFF, 0, 0, 0);
        expect_out("take_src2", 1'b1, 32'h8000_0012, 16'h0000);
        drive(16'h0000, 16'hFFFF, 0, 1, 0);
        expect_out("mret_src2", 1'b0, 32'h8000_0012, 16'h0004);

        // Exception from IDLE beats a pending request
        drive(16'h0001, 16'hFFFF, 1, 0, 0);
        expect_out("idle_exc", 1'b0, 32'h8000_0012, 16'h0000);
        drive(16'h0001, 16'hFFFF, 0, 0, 0);
        expect_out("exc_hold", 1'b0, 32'h8000_0012, 16'h0000);
        drive(16'h0001, 16'hFFFF, 1, 1, 0);
        expect_out("exc_mret", 1'b0, 32'h8000_0012, 16'h0000);
        drive(16'h0001, 16'hFFFF, 0, 0, 0);
        expect_out("retake_src0", 1'b1, 32'h8000_0010, 16'h0000);
        drive(16'h0000, 16'hFFFF, 0, 1, 0);
        expect_out("mret_src0b", 1'b0, 32'h8000_0010, 16'h0001);

        // Exception nested inside interrupt handler
        drive(16'h0008, 16'hFFFF, 0, 0, 0);
        expect_out("take_src3", 1'b1, 32'h8000_0013, 16'h0000);
        drive(16'h0000, 16'hFFFF, 1, 0, 0);
        expect_out("irq_exc", 1'b0, 32'h8000_0013, 16'h0000);
        drive(16'h0000, 16'hFFFF, 0, 1, 0);
        expect_out("irqexc_mret", 1'b0, 32'h8000_0013, 16'h0000);
        drive(16'h0001, 16'hFFFF, 0, 0, 0);
        expect_out("back_in_irq", 1'b0, 32'h8000_0013, 16'h0000);
        drive(16'h0000, 16'hFFFF, 0, 1, 0);
        expect_out("mret_src3", 1'b0, 32'h8000_0013, 16'h0008);

        // Simultaneous exception and mret in IRQ: exception wins
        drive(16'h0020, 16'hFFFF, 0, 0, 0);
        expect_out("take_src5", 1'b1, 32'h8000_0015, 16'h0000);
        drive(16'h0000, 16'hFFFF, 1, 1, 0);
        expect_out("exc_mret_same", 1'b0, 32'h8000_0015, 16'h0000);
        drive(16'h0000, 16'hFFFF, 0, 0, 0);
        expect_out("in_irq_exc", 1'b0, 32'h8000_0015, 16'h0000);
        drive(16'h0000, 16'hFFFF, 0, 1, 0);
        expect_out("irqexc_mret5", 1'b0, 32'h8000_0015, 16'h0000);
        drive(16'h0000, 16'hFFFF, 0, 1, 0);
        expect_out("mret_src5", 1'b0, 32'h8000_0015, 16'h0020);

        // Reset mid-service with request held
        drive(16'h0002, 16'hFFFF, 0, 0, 0);
        expect_out("take_src1", 1'b1, 32'h8000_0011, 16'h0000);
        drive(16'h0002, 16'hFFFF, 0, 1, 1);
        expect_out("reset_mid", 1'b0, 32'h8000_0010, 16'h0000);
        drive(16'h0002, 16'hFFFF, 0, 0, 0);
        expect_out("after_reset", 1'b1, 32'h8000_0011, 16'h0000);
        drive(16'h0002, 16'hFFFF, 0, 1, 0);
        expect_out("mret_src1", 1'b0, 32'h8000_0011, 16'h0002);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/irq_controller.md
IRQ_CONTROLLER -- requirements
Module: irq_controller

Interface
REQ-001 Parameter IRQ_NUM, default 16: number of interrupt sources, legal range 1..16.
REQ-002 Parameter CAUSE_BASE, default 16: mcause code of source 0; source i reports code CAUSE_BASE+i.
REQ-003 Clock and reset: one clock, clk_i; reset rst_i is asynchronous and active-high.
REQ-004 clk_i  in  1  system clock; all state updates on the rising edge.
REQ-005 rst_i  in  1  asynchronous active-high reset.
REQ-006 irq_req_i  in  IRQ_NUM  level interrupt requests from peripherals.
REQ-007 mie_i  in  IRQ_NUM  per-source enable mask from the mie CSR.
REQ-008 exception_i  in  1  core reports a synchronous exception this cycle.
REQ-009 mret_i  in  1  core executes mret this cycle.
REQ-010 irq_o  out  1  interrupt trap request to the core, one-cycle pulse.
REQ-011 irq_cause_o  out  32  mcause value for the interrupt being taken or in service.
REQ-012 irq_ret_o  out  IRQ_NUM  one-hot completion acknowledge to the serviced peripheral.

Function
REQ-013 pending = irq_req_i & mie_i; selected source = lowest set index of pending (index 0 highest priority).
REQ-014 FSM states: IDLE, IRQ (interrupt in service), EXC (exception handler, no interrupt), IRQ_EXC (exception nested inside interrupt handler).
REQ-015 IDLE: exception_i=1 -> EXC; else pending!=0 -> IRQ; else stay; mret_i ignored.
REQ-016 irq_o = 1 combinationally only in IDLE with pending!=0 and exception_i=0; 0 in all other states.
REQ-017 On the edge leaving IDLE for IRQ, latch selected index into in-service register svc_idx.
REQ-018 irq_cause_o = 0x8000_0000 | (CAUSE_BASE + selected index) while irq_o=1; otherwise 0x8000_0000 | (CAUSE_BASE + svc_idx).
REQ-019 IRQ: exception_i=1 -> IRQ_EXC (exception wins over simultaneous mret_i, no acknowledge); else mret_i=1 -> IDLE.
REQ-020 irq_ret_o = one-hot(svc_idx) combinationally in IRQ with mret_i=1 and exception_i=0; all zeros otherwise.
REQ-021 EXC: mret_i=1 -> IDLE; exception_i ignored (stay).
REQ-022 IRQ_EXC: mret_i=1 -> IRQ (no acknowledge); exception_i ignored.
REQ-023 Requests are level-sensitive and never latched; a request dropped before acceptance is lost without error.
REQ-024 Changes to irq_req_i or mie_i while not in IDLE do not affect svc_idx, irq_cause_o or the FSM.
REQ-025 A still-asserted request is re-taken on the first IDLE cycle after return, with the normal one-cycle irq_o pulse.
REQ-026 At most one interrupt in service; no interrupt nesting.

Reset
REQ-027 rst_i=1 forces, asynchronously: state IDLE, svc_idx 0, irq_o 0, irq_ret_o 0.
REQ-028 irq_cause_o during reset = 0x8000_0000 | CAUSE_BASE.
REQ-029 Reset mid-service drops the service silently, with no irq_ret_o pulse; requests held high are re-accepted one cycle after release.

Verification
REQ-030 After reset, irq_req_i=0x0001, mie_i=0xFFFF -> irq_o=1 for one cycle, irq_cause_o=0x8000_0010, state IRQ; mret_i pulse -> irq_ret_o=0x0001 same cycle, IDLE next edge.
REQ-031 irq_req_i=0x0014, mie_i=0x0010 -> source 4 taken, cause 0x8000_0014; with mie_i=0xFFFF instead -> source 2, cause 0x8000_0012.
REQ-032 In IDLE, exception_i=1 with pending=0x0001 -> irq_o=0, state EXC; mret_i -> IDLE, irq_ret_o=0, then irq_o pulses next cycle.
REQ-033 In IRQ(source 3), exception_i -> IRQ_EXC; first mret_i -> IRQ, irq_ret_o=0; second mret_i -> irq_ret_o=0x0008, IDLE.
REQ-034 In IRQ, exception_i and mret_i same cycle -> IRQ_EXC, irq_ret_o=0.
REQ-035 rst_i pulse while in IRQ with request held -> outputs zero, irq_ret_o never pulses; irq_o pulses in the first cycle after rst_i falls.
